// File: rtl/mnist_host_seq.sv
// mnist_host_seq: host-side load/compute sequencer with 7-seg result display.
// Define MNIST_HOST_SCAN_EN for continuous auto-incrementing image scan.
module mnist_host_seq #(
   parameter int NUM_IMAGES     = 16,
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       go,
   input  logic [3:0] image_sel,
   output logic       load_params,
   output logic       start_comp,
   output logic [3:0] image_num,
   input  logic       ready,
   input  logic [9:0] classes,
   output logic [3:0] result_digit,
   output logic       result_valid,
   output logic       busy,
   output logic       err,
   output logic [7:0] hex
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      RST_LOAD, LOAD_ACK, LOAD_DONE, IDLE, START_ACK,
      COMP_DONE, CAPTURE, DONE, ERR
   } state_t;

   state_t                 r_state, w_nxt;
   logic [SYNC_STAGES-1:0] r_go_s, r_rdy_s;
   logic                   r_go_q, r_upd;
   logic                   r_load, r_start, r_busy, r_valid, r_err;
   logic [TW-1:0]          r_tmo;
   logic [9:0]             r_cls;
   logic [3:0]             r_img, r_digit, w_img, w_sel, w_enc;
   logic [7:0]             r_hex;
   logic                   w_go_rise, w_rdy, w_tmo, w_launch, w_cls_ok;

   function automatic logic f_onehot(input logic [9:0] c);
      return (c != '0) && ((c & (c - 10'd1)) == '0);
   endfunction

   function automatic logic [7:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // ready idles high, so its synchronizer resets to 1 to avoid a false ack
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_go_s  <= '0;
         r_rdy_s <= '1;
         r_go_q  <= 1'b0;
      end else begin
         r_go_s[0]  <= go;
         r_rdy_s[0] <= ready;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_go_s[i]  <= r_go_s[i-1];
            r_rdy_s[i] <= r_rdy_s[i-1];
         end
         r_go_q <= r_go_s[SYNC_STAGES-1];
      end
   end

   assign w_go_rise = r_go_s[SYNC_STAGES-1] & ~r_go_q;
   assign w_rdy     = r_rdy_s[SYNC_STAGES-1];
   assign w_sel     = (32'(image_sel) >= NUM_IMAGES) ? 4'd0 : image_sel;
   assign w_cls_ok  = f_onehot(r_cls);
   assign w_tmo     = (r_state inside {LOAD_ACK, LOAD_DONE, START_ACK, COMP_DONE})
                      && (r_tmo == '0);

   always_comb begin
      w_enc = 4'd0;
      for (int i = 0; i < 10; i++)
         if (r_cls[i]) w_enc = 4'(i);
   end

`ifdef MNIST_HOST_SCAN_EN
   logic       r_pause;
   logic [3:0] w_wrap;
   assign w_wrap = (32'(r_img) >= NUM_IMAGES - 1) ? 4'd0 : r_img + 4'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_pause <= 1'b0;
      else if (w_go_rise && (r_state inside {START_ACK, COMP_DONE, CAPTURE, DONE}))
         r_pause <= ~r_pause;
   end
`endif

   always_comb begin
      w_nxt    = r_state;
      w_launch = 1'b0;
      w_img    = r_img;
      unique case (r_state)
         RST_LOAD:  w_nxt = LOAD_ACK;
         LOAD_ACK:  if (!w_rdy) w_nxt = LOAD_DONE;
         LOAD_DONE: if (w_rdy) w_nxt = IDLE;
         IDLE: begin
            if (w_go_rise) begin
               w_launch = 1'b1;
               w_img    = w_sel;
            end
         end
         START_ACK: if (!w_rdy) w_nxt = COMP_DONE;
         COMP_DONE: if (w_rdy) w_nxt = CAPTURE;
         CAPTURE:   w_nxt = f_onehot(classes) ? DONE : ERR;
         DONE: begin
`ifdef MNIST_HOST_SCAN_EN
            if (!r_pause && !w_go_rise) begin
               w_launch = 1'b1;
               w_img    = w_wrap;
            end
`else
            if (w_go_rise) begin
               w_launch = 1'b1;
               w_img    = w_sel;
            end
`endif
         end
         default:   w_nxt = ERR;
      endcase
      if (w_launch) w_nxt = START_ACK;
      if (w_tmo) w_nxt = ERR;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RST_LOAD;
         r_tmo   <= TMO_RELOAD;
         r_load  <= 1'b0;
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_img   <= 4'd0;
         r_upd   <= 1'b0;
         r_cls   <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_nxt != r_state)
            r_tmo <= TMO_RELOAD;
         else if (r_tmo != '0)
            r_tmo <= r_tmo - TW'(1);
         r_load  <= (w_nxt == LOAD_ACK) || (w_nxt == LOAD_DONE);
         r_start <= (w_nxt == START_ACK) || (w_nxt == COMP_DONE);
         r_busy  <= !((w_nxt == IDLE) || (w_nxt == DONE));
         r_img   <= w_img;
         r_upd   <= (r_state == CAPTURE);
         if (r_state == CAPTURE) r_cls <= classes;
      end
   end

   // the captured vector is encoded one clock after CAPTURE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         r_digit <= 4'd0;
         r_hex   <= 8'hFF;
      end else if (w_tmo || (r_upd && !w_cls_ok)) begin
         r_err   <= 1'b1;
         r_valid <= 1'b0;
         r_digit <= 4'hF;
         r_hex   <= 8'h86;
`ifndef MNIST_HOST_SCAN_EN
      end else if (w_launch) begin
         r_valid <= 1'b0;
         r_hex   <= 8'hFF;
`endif
      end else if (r_upd) begin
         r_valid <= 1'b1;
         r_digit <= w_enc;
         r_hex   <= f_seg(w_enc);
`ifdef MNIST_HOST_SCAN_EN
      end else begin
         r_valid <= 1'b0;
`endif
      end
   end

   assign load_params  = r_load;
   assign start_comp   = r_start;
   assign image_num    = r_img;
   assign result_digit = r_digit;
   assign result_valid = r_valid;
   assign busy         = r_busy;
   assign err          = r_err;
   assign hex          = r_hex;
endmodule

// File: doc/mnist_host_seq.md
# mnist_host_seq

Host-side command sequencer for the MNIST systolic-array accelerator wrapper. It is the initiator end of the accelerator's `load_params`/`start_comp`/`ready` handshake. After reset it loads weights once. It then launches one classification per user trigger, captures the one-hot `classes` vector, encodes it to a digit and drives one active-low seven-segment display. It sits between board switches/keys and the accelerator wrapper in the board top.

## Interface
Parameters:
- `NUM_IMAGES`, 16: number of stored images; `image_num` wraps at `NUM_IMAGES-1`.
- `TIMEOUT_CYCLES`, 2_000_000: maximum cycles to wait for any `ready` edge before the error state.
- `SYNC_STAGES`, 2: synchronizer depth on `go` and `ready`.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: asynchronous user trigger; a rising edge (after sync) requests one classification.
- `image_sel` in 4: image index, sampled on the accepted `go` edge.
- `load_params` out 1: accelerator weight-load command (level).
- `start_comp` out 1: accelerator compute command (level).
- `image_num` out 4: image index presented to the accelerator.
- `ready` in 1: accelerator done/idle level; synchronized internally.
- `classes` in 10: accelerator one-hot result; sampled only in CAPTURE.
- `result_digit` out 4: encoded class 0–9; 4'hF on error.
- `result_valid` out 1: high while `result_digit` holds a fresh result.
- `busy` out 1: high in every state except IDLE and DONE.
- `err` out 1: sticky error (timeout or non-one-hot result).
- `hex` out 8: active-low seven-segment display, bit 7 = dp.

## Operation
- States: RST_LOAD, LOAD_ACK, LOAD_DONE, IDLE, START_ACK, COMP_DONE, CAPTURE, DONE, ERR.
- Command handshake, identical for load and compute:
  - Assert the command.
  - Wait for synchronized `ready` = 0 (ack).
  - Wait for `ready` = 1 (done).
  - Deassert the command in the same cycle `ready`=1 is seen.
- RST_LOAD: first cycle after reset. Raise `load_params`, go to LOAD_ACK.
- LOAD_ACK → LOAD_DONE when `ready`=0.
- LOAD_DONE → IDLE when `ready`=1, dropping `load_params`.
- IDLE: on a `go` rising edge, latch `image_sel` into `image_num`, raise `start_comp`, go to START_ACK. If `image_sel` ≥ `NUM_IMAGES`, latch 0 instead.
- START_ACK → COMP_DONE when `ready`=0.
- COMP_DONE → CAPTURE when `ready`=1, dropping `start_comp`.
- CAPTURE: register `classes` and encode the digit from the set-bit index.
  - Exactly one bit set: set `result_valid`, go to DONE.
  - Zero or several bits set: set `err`, `result_digit`=4'hF, go to ERR.
- DONE behaves as IDLE: a new `go` edge clears `result_valid` and relaunches.
- ERR is terminal until reset. Commands are deasserted; `hex` shows "E" (8'h86).
- Timeout: one down-counter reloads to `TIMEOUT_CYCLES` on every state change. Reaching 0 in any *_ACK/*_DONE state sets `err`, drops both commands, and goes to ERR.
- `go` edges outside IDLE/DONE are discarded, not queued.
- `load_params` and `start_comp` are never high together.
- `hex` patterns:
  - Digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - No `result_valid` and no `err`: FF (blank).

## Timing
- Reset values:
  - `load_params`=0, `start_comp`=0, `image_num`=0.
  - `result_digit`=0, `result_valid`=0, `busy`=0, `err`=0, `hex`=8'hFF.
  - The state register resets to RST_LOAD.
- `load_params` rises on the first clock after `reset_n` deasserts, so `busy`=1 from that cycle.
- `go` edge-to-`start_comp` latency: `SYNC_STAGES`+1 clocks.
- `ready` is synchronized `SYNC_STAGES` deep. The command drops `SYNC_STAGES`+1 clocks after the raw `ready` rises.
- `result_valid`, `result_digit` and `hex` update 1 clock after CAPTURE, i.e. 2 clocks after the command drops.
- A `reset_n` assertion mid-transaction clears all outputs immediately. The load sequence then restarts.
- All outputs are registered.

## Configuration
- `MNIST_HOST_SCAN_EN`, when defined: after DONE, the block automatically increments `image_num` modulo `NUM_IMAGES` and relaunches after a 1-clock gap, scanning continuously.
  - A `go` edge toggles scan pause/resume.
  - `result_valid` pulses for 1 clock per result; `hex` holds the last result.
- When undefined: single-shot behaviour as described in Operation.

## Test plan
- Reset release, accelerator model acks in 3 clocks and completes in 10 → `load_params` high for exactly that window, then IDLE with `busy`=0 and `hex`=FF.
- `image_sel`=5, `go` pulse, model returns `classes`=10'b00_0000_1000 → `image_num`=5, one `start_comp` window, `result_digit`=3, `hex`=B0, `result_valid`=1.
- Model returns `classes`=10'b0000000101 → `err`=1, `result_digit`=F, `hex`=86, later `go` edges ignored.
- `TIMEOUT_CYCLES`=50 with `ready` held high (never acks) → `err` at cycle 50 of START_ACK, `start_comp`=0.
- `go` toggled during COMP_DONE, then `reset_n` pulsed mid-compute → no second launch, all outputs at reset values, `load_params` re-asserts.
- With `MNIST_HOST_SCAN_EN`, `NUM_IMAGES`=3 → `image_num` sequence 0,1,2,0 with one `result_valid` pulse per image.
